llc_snoop_responder: RTL and testbench

Bus-side snoop responder for the last-level cache. Accepts one snooped bus operation at a time from other processors (READ, WRITE, INVALIDATE, RWIM), looks the line up in the tag/MESI array, and drives the snoop result. It then issues the required L1 messages and the write-back of a modified line, and updates the MESI state. This is the responder counterpart to the cache's own bus-operation initiator.

---
 rtl/llc_snoop_responder_pkg.sv | 42 ++++
 rtl/llc_snoop_responder_way_match.sv | 32 +++
 rtl/llc_snoop_responder.sv | 207 ++++++++++++++++++++
 tb/tb_llc_snoop_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_snoop_responder_pkg.sv
// Shared LLC configuration: address split, MESI/bus/snoop/L1 encodings and the
// per-snoop action bundle produced by the responder's decision stage.
package llc_snoop_responder_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned WAYS   = 16;
   localparam int unsigned WAY_W  = 4;
   localparam int unsigned TAG_W  = 12;
   localparam int unsigned IDX_W  = 14;
   localparam int unsigned OFF_W  = 6;
   localparam int unsigned LINE_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {
      MESI_M = 2'd0, MESI_E = 2'd1, MESI_S = 2'd2, MESI_I = 2'd3
   } mesi_e;

   typedef enum logic [1:0] {
      OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INVALIDATE = 2'd2, OP_RWIM = 2'd3
   } bus_op_e;

   typedef enum logic [1:0] {
      RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2
   } snoop_res_e;

   typedef enum logic [1:0] {
      MSG_GETLINE = 2'd0, MSG_SENDLINE = 2'd1, MSG_INVALIDATELINE = 2'd2, MSG_EVICTLINE = 2'd3
   } l1_msg_e;

   typedef struct packed {
      logic [1:0] res;
      logic       err;
      logic       getl;
      logic       inv;
      logic       upd;
      logic [1:0] new_mesi;
   } snp_act_t;

   function automatic logic [ADDR_W-1:0] line_addr(input logic [LINE_W-1:0] line);
      return {line, OFF_W'(0)};
   endfunction

endpackage

// File: rtl/llc_snoop_responder_way_match.sv
// Tag compare across all valid ways with lowest-way priority and multi-hit flag.
module llc_way_match
   import llc_snoop_responder_pkg::*;
(
   input  logic [TAG_W-1:0]      tag,
   input  logic [WAYS*TAG_W-1:0] arr_tag,
   input  logic [WAYS*2-1:0]     arr_mesi,
   output logic                  hit,
   output logic [3:0]            way,
   output logic [1:0]            mesi,
   output logic                  multi_hit
);

   always_comb begin
      hit       = 1'b0;
      way       = 4'd0;
      mesi      = MESI_I;
      multi_hit = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         if (arr_mesi[2*i +: 2] != MESI_I && arr_tag[TAG_W*i +: TAG_W] == tag) begin
            if (hit) begin
               multi_hit = 1'b1;
            end else begin
               hit  = 1'b1;
               way  = 4'(i);
               mesi = arr_mesi[2*i +: 2];
            end
         end
      end
   end

endmodule

// File: rtl/llc_snoop_responder.sv
// LLC bus-side snoop responder: look up a snooped line, report HIT/HITM/NOHIT,
// then issue L1 messages, write back a modified line and update MESI.
module llc_snoop_responder
   import llc_snoop_responder_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  snp_valid,
   output logic                  snp_ready,
   input  logic [1:0]            snp_op,
   input  logic [ADDR_W-1:0]     snp_addr,
   output logic                  arr_rd_en,
   output logic [IDX_W-1:0]      arr_idx,
   input  logic [WAYS*TAG_W-1:0] arr_tag,
   input  logic [WAYS*2-1:0]     arr_mesi,
   output logic                  arr_wr_en,
   output logic [3:0]            arr_wr_way,
   output logic [1:0]            arr_wr_mesi,
   output logic                  res_valid,
   output logic [1:0]            res,
   output logic                  l1_valid,
   input  logic                  l1_ready,
   output logic [1:0]            l1_msg,
   output logic [ADDR_W-1:0]     l1_addr,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [ADDR_W-1:0]     wb_addr,
   output logic                  proto_err
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOOKUP, ST_DECIDE, ST_RESP, ST_GETL, ST_WB, ST_INVL, ST_UPD
   } state_e;

   state_e            state;
   bus_op_e           op_q;
   logic [LINE_W-1:0] line_q;
   logic [WAY_W-1:0]  way_q;
   snp_act_t          act_q;
   snp_act_t          act;

   logic              m_hit;
   logic [3:0]        m_way;
   logic [1:0]        m_mesi;
   logic              m_multi;
   logic              unused_off;

   assign unused_off = ^snp_addr[OFF_W-1:0];

   llc_way_match u_match (
      .tag       (line_q[LINE_W-1 -: TAG_W]),
      .arr_tag   (arr_tag),
      .arr_mesi  (arr_mesi),
      .hit       (m_hit),
      .way       (m_way),
      .mesi      (m_mesi),
      .multi_hit (m_multi)
   );

   // Snoop action table: response, protocol error and follow-up work.
   always_comb begin
      act          = '0;
      act.res      = RES_NOHIT;
      act.err      = m_multi;
      act.new_mesi = MESI_I;
      if (m_hit) begin
         unique case (op_q)
            OP_READ: begin
               if (m_mesi == MESI_M) begin
                  act.res = RES_HITM; act.getl = 1'b1; act.upd = 1'b1; act.new_mesi = MESI_S;
               end else if (m_mesi == MESI_E) begin
                  act.res = RES_HIT; act.upd = 1'b1; act.new_mesi = MESI_S;
               end else begin
                  act.res = RES_HIT;
               end
            end
            OP_RWIM: begin
               act.res  = (m_mesi == MESI_M) ? 2'(RES_HITM) : 2'(RES_HIT);
               act.getl = (m_mesi == MESI_M);
               act.inv  = 1'b1;
               act.upd  = 1'b1;
            end
            OP_INVALIDATE: begin
               if (m_mesi == MESI_S) begin
                  act.res = RES_HIT; act.inv = 1'b1; act.upd = 1'b1;
               end else begin
                  act.err = 1'b1;
               end
            end
            OP_WRITE: act.err = 1'b1;
            default: act.err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         op_q        <= OP_READ;
         line_q      <= '0;
         way_q       <= '0;
         act_q       <= '0;
         snp_ready   <= 1'b0;
         arr_rd_en   <= 1'b0;
         arr_idx     <= '0;
         arr_wr_en   <= 1'b0;
         arr_wr_way  <= '0;
         arr_wr_mesi <= '0;
         res_valid   <= 1'b0;
         res         <= '0;
         l1_valid    <= 1'b0;
         l1_msg      <= '0;
         l1_addr     <= '0;
         wb_valid    <= 1'b0;
         wb_addr     <= '0;
         proto_err   <= 1'b0;
      end else begin
         arr_rd_en <= 1'b0;
         arr_wr_en <= 1'b0;
         res_valid <= 1'b0;
         proto_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (snp_valid && snp_ready) begin
                  snp_ready <= 1'b0;
                  op_q      <= bus_op_e'(snp_op);
                  line_q    <= snp_addr[ADDR_W-1:OFF_W];
                  arr_idx   <= snp_addr[OFF_W +: IDX_W];
                  arr_rd_en <= 1'b1;
                  state     <= ST_LOOKUP;
               end else begin
                  snp_ready <= 1'b1;
               end
            end
            ST_LOOKUP: state <= ST_DECIDE;
            ST_DECIDE: begin
               res_valid <= 1'b1;
               res       <= act.res;
               proto_err <= act.err;
               act_q     <= act;
               way_q     <= m_way;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (act_q.getl) begin
                  l1_valid <= 1'b1;
                  l1_msg   <= MSG_GETLINE;
                  l1_addr  <= line_addr(line_q);
                  state    <= ST_GETL;
               end else if (act_q.inv) begin
                  l1_valid <= 1'b1;
                  l1_msg   <= MSG_INVALIDATELINE;
                  l1_addr  <= line_addr(line_q);
                  state    <= ST_INVL;
               end else if (act_q.upd) begin
                  arr_wr_en   <= 1'b1;
                  arr_wr_way  <= way_q;
                  arr_wr_mesi <= act_q.new_mesi;
                  state       <= ST_UPD;
               end else begin
                  snp_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            ST_GETL: begin
               if (l1_ready) begin
                  l1_valid <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_addr  <= line_addr(line_q);
                  state    <= ST_WB;
               end
            end
            ST_WB: begin
               if (wb_ready) begin
                  wb_valid <= 1'b0;
                  if (act_q.inv) begin
                     l1_valid <= 1'b1;
                     l1_msg   <= MSG_INVALIDATELINE;
                     l1_addr  <= line_addr(line_q);
                     state    <= ST_INVL;
                  end else begin
                     arr_wr_en   <= 1'b1;
                     arr_wr_way  <= way_q;
                     arr_wr_mesi <= act_q.new_mesi;
                     state       <= ST_UPD;
                  end
               end
            end
            ST_INVL: begin
               if (l1_ready) begin
                  l1_valid    <= 1'b0;
                  arr_wr_en   <= 1'b1;
                  arr_wr_way  <= way_q;
                  arr_wr_mesi <= act_q.new_mesi;
                  state       <= ST_UPD;
               end
            end
            ST_UPD: begin
               snp_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Scoreboard bench for llc_snoop_responder: expected events queued per snoop,
// popped and compared as the responder produces them.
module tb_llc_snoop_responder;
   import llc_snoop_responder_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  snp_valid;
   logic                  snp_ready;
   logic [1:0]            snp_op;
   logic [ADDR_W-1:0]     snp_addr;
   logic                  arr_rd_en;
   logic [IDX_W-1:0]      arr_idx;
   logic [WAYS*TAG_W-1:0] arr_tag;
   logic [WAYS*2-1:0]     arr_mesi;
   logic                  arr_wr_en;
   logic [3:0]            arr_wr_way;
   logic [1:0]            arr_wr_mesi;
   logic                  res_valid;
   logic [1:0]            res;
   logic                  l1_valid;
   logic                  l1_ready;
   logic [1:0]            l1_msg;
   logic [ADDR_W-1:0]     l1_addr;
   logic                  wb_valid;
   logic                  wb_ready;
   logic [ADDR_W-1:0]     wb_addr;
   logic                  proto_err;

   always #5 clk = ~clk;

   llc_snoop_responder dut (
      .clk(clk), .rst_n(rst_n), .snp_valid(snp_valid), .snp_ready(snp_ready),
      .snp_op(snp_op), .snp_addr(snp_addr), .arr_rd_en(arr_rd_en), .arr_idx(arr_idx),
      .arr_tag(arr_tag), .arr_mesi(arr_mesi), .arr_wr_en(arr_wr_en),
      .arr_wr_way(arr_wr_way), .arr_wr_mesi(arr_wr_mesi), .res_valid(res_valid),
      .res(res), .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_msg(l1_msg),
      .l1_addr(l1_addr), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
      .proto_err(proto_err)
   );

   // Single-set array model driven onto the lookup bus.
   logic [TAG_W-1:0] tag_m  [WAYS];
   logic [1:0]       mesi_m [WAYS];
   for (genvar g = 0; g < WAYS; g++) begin : g_arr
      assign arr_tag[TAG_W*g +: TAG_W] = tag_m[g];
      assign arr_mesi[2*g +: 2]        = mesi_m[g];
   end

   localparam int K_RES = 0, K_ERR = 1, K_WR = 2, K_L1 = 3, K_WB = 4;
   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [3:0]  b;
   } ev_t;

   ev_t sb[$];
   int  passed = 0;
   int  total  = 0;
   int  res_cyc, ready_cyc, l1_hs_cyc, wb_first_cyc;

   task automatic expect_ev(input int kind, input logic [31:0] a, input logic [3:0] b);
      ev_t e;
      e.kind = kind; e.a = a; e.b = b;
      sb.push_back(e);
   endtask

   task automatic clear_array();
      for (int i = 0; i < WAYS; i++) begin
         tag_m[i]  = TAG_W'(i + 16'h0A00);
         mesi_m[i] = MESI_I;
      end
   endtask

   task automatic run_txn(input logic [1:0] op, input logic [31:0] addr,
                          input int l1_stall, input int wb_stall);
      int          cyc, l1_cnt, wb_cnt;
      logic [31:0] l1_addr0;
      logic [1:0]  l1_msg0;
      logic        done;
      ev_t         obs[$];
      ev_t         o, e;
      res_cyc = -1; ready_cyc = -1; l1_hs_cyc = -1; wb_first_cyc = -1;
      l1_cnt = 0; wb_cnt = 0; l1_addr0 = '0; l1_msg0 = '0;
      @(negedge clk);
      for (int k = 0; k < 20 && !snp_ready; k++) @(negedge clk);
      snp_valid = 1'b1; snp_op = op; snp_addr = addr;
      l1_ready = 1'b0; wb_ready = 1'b0;
      @(negedge clk);
      snp_valid = 1'b0;
      cyc = 1;
      total++;
      if (arr_rd_en !== 1'b1 || arr_idx !== addr[19:6]) begin
         $display("FAIL lookup: rd_en=%b idx=%h required rd_en=1 idx=%h", arr_rd_en, arr_idx, addr[19:6]);
      end else passed++;
      done = 1'b0;
      while (!done) begin
         obs.delete();
         if (res_valid) begin
            o.kind = K_RES; o.a = '0; o.b = 4'(res); obs.push_back(o);
            res_cyc = cyc;
         end
         if (proto_err) begin
            o.kind = K_ERR; o.a = '0; o.b = '0; obs.push_back(o);
         end
         if (arr_wr_en) begin
            o.kind = K_WR; o.a = 32'(arr_wr_mesi); o.b = arr_wr_way; obs.push_back(o);
         end
         if (l1_valid) begin
            if (l1_cnt == 0) begin
               l1_addr0 = l1_addr; l1_msg0 = l1_msg;
            end else begin
               total++;
               if (l1_addr !== l1_addr0 || l1_msg !== l1_msg0) begin
                  $display("FAIL l1_hold: addr=%h msg=%0d required addr=%h msg=%0d", l1_addr, l1_msg, l1_addr0, l1_msg0);
               end else passed++;
            end
            l1_ready = (l1_cnt >= l1_stall);
            l1_cnt++;
            if (l1_ready) begin
               o.kind = K_L1; o.a = l1_addr; o.b = 4'(l1_msg); obs.push_back(o);
               l1_hs_cyc = cyc; l1_cnt = 0;
            end
         end else l1_ready = 1'b0;
         if (wb_valid) begin
            if (wb_first_cyc < 0) wb_first_cyc = cyc;
            wb_ready = (wb_cnt >= wb_stall);
            wb_cnt++;
            if (wb_ready) begin
               o.kind = K_WB; o.a = wb_addr; o.b = '0; obs.push_back(o);
               wb_cnt = 0;
            end
         end else wb_ready = 1'b0;
         foreach (obs[i]) begin
            total++;
            if (sb.size() == 0) begin
               $display("FAIL event: unexpected kind=%0d a=%h b=%0d at cycle %0d", obs[i].kind, obs[i].a, obs[i].b, cyc);
            end else begin
               e = sb.pop_front();
               if (obs[i].kind !== e.kind || obs[i].a !== e.a || obs[i].b !== e.b)
                  $display("FAIL event: got kind=%0d a=%h b=%0d required kind=%0d a=%h b=%0d",
                           obs[i].kind, obs[i].a, obs[i].b, e.kind, e.a, e.b);
               else passed++;
            end
         end
         if (snp_ready && cyc > 1) begin
            ready_cyc = cyc; done = 1'b1;
         end else if (cyc >= 80) begin
            total++;
            $display("FAIL timeout: snp_ready=%b after %0d cycles required 1", snp_ready, cyc);
            done = 1'b1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      l1_ready = 1'b0; wb_ready = 1'b0;
      total++;
      if (sb.size() != 0) $display("FAIL missing: %0d events outstanding required 0", sb.size());
      else passed++;
      sb.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({snp_ready, arr_rd_en, arr_wr_en, res_valid, l1_valid, wb_valid, proto_err} !== 7'b0)
         $display("FAIL reset_outs: got %b required 0", {snp_ready, arr_rd_en, arr_wr_en, res_valid, l1_valid, wb_valid, proto_err});
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (snp_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", snp_ready);
      else passed++;
   endtask

   task automatic test_read_hitm();
      clear_array();
      tag_m[5] = 12'h123; mesi_m[5] = MESI_M;
      expect_ev(K_RES, 0, 4'(RES_HITM));
      expect_ev(K_L1, 32'h1234_5680, 4'(MSG_GETLINE));
      expect_ev(K_WB, 32'h1234_5680, 0);
      expect_ev(K_WR, 32'(MESI_S), 4'd5);
      run_txn(OP_READ, 32'h1234_5680, 0, 0);
      total++;
      if (res_cyc != 3) $display("FAIL res_cycle: got %0d required 3", res_cyc);
      else passed++;
   endtask

   task automatic test_rwim_shared();
      clear_array();
      tag_m[0] = 12'h000; mesi_m[0] = MESI_S;
      expect_ev(K_RES, 0, 4'(RES_HIT));
      expect_ev(K_L1, 32'h0000_0040, 4'(MSG_INVALIDATELINE));
      expect_ev(K_WR, 32'(MESI_I), 4'd0);
      run_txn(OP_RWIM, 32'h0000_0040, 0, 0);
   endtask

   task automatic test_read_miss();
      clear_array();
      mesi_m[4] = MESI_M;
      mesi_m[9] = MESI_S;
      tag_m[12] = 12'h123;
      expect_ev(K_RES, 0, 4'(RES_NOHIT));
      run_txn(OP_READ, 32'h1234_5680, 0, 0);
      total++;
      if (ready_cyc != 4) $display("FAIL miss_ready: got cycle %0d required 4", ready_cyc);
      else passed++;
   endtask

   task automatic test_read_shared_and_e();
      clear_array();
      tag_m[8] = 12'hABC; mesi_m[8] = MESI_S;
      expect_ev(K_RES, 0, 4'(RES_HIT));
      run_txn(OP_READ, 32'hABC0_0FC0, 0, 0);
      total++;
      if (ready_cyc != 4) $display("FAIL shared_ready: got cycle %0d required 4", ready_cyc);
      else passed++;
      mesi_m[8] = MESI_E;
      expect_ev(K_RES, 0, 4'(RES_HIT));
      expect_ev(K_WR, 32'(MESI_S), 4'd8);
      run_txn(OP_READ, 32'hABC0_0FC0, 0, 0);
   endtask

   task automatic test_l1_stall();
      clear_array();
      tag_m[5] = 12'h123; mesi_m[5] = MESI_M;
      expect_ev(K_RES, 0, 4'(RES_HITM));
      expect_ev(K_L1, 32'h1234_5680, 4'(MSG_GETLINE));
      expect_ev(K_WB, 32'h1234_5680, 0);
      expect_ev(K_WR, 32'(MESI_S), 4'd5);
      run_txn(OP_READ, 32'h1234_56BF, 5, 2);
      total++;
      if (wb_first_cyc != l1_hs_cyc + 1)
         $display("FAIL wb_start: got cycle %0d required %0d", wb_first_cyc, l1_hs_cyc + 1);
      else passed++;
   endtask

   task automatic test_rwim_modified();
      clear_array();
      tag_m[15] = 12'hFFF; mesi_m[15] = MESI_M;
      expect_ev(K_RES, 0, 4'(RES_HITM));
      expect_ev(K_L1, 32'hFFF0_0000, 4'(MSG_GETLINE));
      expect_ev(K_WB, 32'hFFF0_0000, 0);
      expect_ev(K_L1, 32'hFFF0_0000, 4'(MSG_INVALIDATELINE));
      expect_ev(K_WR, 32'(MESI_I), 4'd15);
      run_txn(OP_RWIM, 32'hFFF0_0001, 1, 1);
   endtask

   task automatic test_invalidate();
      clear_array();
      tag_m[6] = 12'h321; mesi_m[6] = MESI_S;
      expect_ev(K_RES, 0, 4'(RES_HIT));
      expect_ev(K_L1, 32'h3210_0100, 4'(MSG_INVALIDATELINE));
      expect_ev(K_WR, 32'(MESI_I), 4'd6);
      run_txn(OP_INVALIDATE, 32'h3210_0100, 0, 0);
      mesi_m[6] = MESI_E;
      expect_ev(K_RES, 0, 4'(RES_NOHIT));
      expect_ev(K_ERR, 0, 0);
      run_txn(OP_INVALIDATE, 32'h3210_0100, 0, 0);
   endtask

   task automatic test_write_proto();
      clear_array();
      tag_m[3] = 12'h123; mesi_m[3] = MESI_E;
      expect_ev(K_RES, 0, 4'(RES_NOHIT));
      expect_ev(K_ERR, 0, 0);
      run_txn(OP_WRITE, 32'h1234_5680, 0, 0);
      total++;
      if (ready_cyc != 4) $display("FAIL write_ready: got cycle %0d required 4", ready_cyc);
      else passed++;
   endtask

   task automatic test_multi_hit();
      clear_array();
      tag_m[2] = 12'h456; mesi_m[2] = MESI_E;
      tag_m[7] = 12'h456; mesi_m[7] = MESI_S;
      expect_ev(K_RES, 0, 4'(RES_HIT));
      expect_ev(K_ERR, 0, 0);
      expect_ev(K_WR, 32'(MESI_S), 4'd2);
      run_txn(OP_READ, 32'h4560_0040, 0, 0);
   endtask

   task automatic test_reset_mid_wb();
      logic seen;
      clear_array();
      tag_m[5] = 12'h123; mesi_m[5] = MESI_M;
      @(negedge clk);
      snp_valid = 1'b1; snp_op = OP_READ; snp_addr = 32'h1234_5680;
      @(negedge clk);
      snp_valid = 1'b0; l1_ready = 1'b1; wb_ready = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         seen = wb_valid;
      end
      total++;
      if (!seen) $display("FAIL rst_wb_reach: wb_valid=%b required 1", wb_valid);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({snp_ready, arr_rd_en, arr_wr_en, res_valid, l1_valid, wb_valid, proto_err,
           l1_addr, wb_addr, arr_idx} !== '0)
         $display("FAIL rst_async: outputs wb_valid=%b l1_valid=%b wb_addr=%h required all 0", wb_valid, l1_valid, wb_addr);
      else passed++;
      l1_ready = 1'b0; wb_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (snp_ready !== 1'b1 || arr_wr_en !== 1'b0 || wb_valid !== 1'b0)
         $display("FAIL rst_release: ready=%b wr_en=%b wb_valid=%b required 1/0/0", snp_ready, arr_wr_en, wb_valid);
      else passed++;
      wb_ready = 1'b0;
   endtask

   initial begin
      snp_valid = 1'b0; snp_op = '0; snp_addr = '0;
      l1_ready = 1'b0; wb_ready = 1'b0;
      clear_array();
      test_reset();
      test_read_hitm();
      test_rwim_shared();
      test_read_miss();
      test_read_shared_and_e();
      test_l1_stall();
      test_rwim_modified();
      test_invalidate();
      test_write_proto();
      test_multi_hit();
      test_reset_mid_wb();
      test_read_hitm();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
